// File: rtl/sa_job_feeder.sv
// Buffers one systolic-array job (SIZE B rows, then N A rows), streams it to the
// flow-control wrapper and forwards the returned C rows downstream.
module sa_job_feeder #(
  parameter int WIDTH      = 16,
  parameter int SIZE       = 4,
  parameter int A_ROWS_MAX = 16,
  parameter int CNTW       = $clog2(A_ROWS_MAX+1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_cfg_vld,
  input  logic [CNTW-1:0]       i_cfg_a_rows,
  output logic                  o_cfg_rdy,
  input  logic                  i_ld_vld,
  input  logic [SIZE*WIDTH-1:0] i_ld_row,
  output logic                  o_ld_rdy,
  output logic                  o_sa_vld,
  output logic                  o_sa_is_b,
  output logic [SIZE*WIDTH-1:0] o_sa_ab,
  input  logic                  i_sa_ready,
  input  logic                  i_c_vld,
  input  logic [SIZE*WIDTH-1:0] i_c,
  output logic                  o_c_ready,
  output logic                  o_res_vld,
  output logic [SIZE*WIDTH-1:0] o_res_c,
  output logic                  o_res_last,
  input  logic                  i_res_rdy,
  output logic                  o_done,
  output logic                  o_busy,
  output logic                  o_err
);
  localparam int DEPTH = SIZE + A_ROWS_MAX;
  localparam int PW    = $clog2(DEPTH);
  localparam int RW    = SIZE * WIDTH;
  localparam logic [PW-1:0]   SIZE_P = PW'(SIZE);
  localparam logic [CNTW-1:0] AMAX_P = CNTW'(A_ROWS_MAX);

  typedef enum logic [2:0] {IDLE, LOAD, SEND, DRAIN, DONE} state_e;

  state_e          state_q, state_d;
  logic [CNTW-1:0] n_q, n_d;
  logic [CNTW-1:0] res_cnt_q, res_cnt_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            err_q, err_d;
  logic [RW-1:0]   mem [DEPTH];

  logic            ld_we, res_act, c_hs, res_fin;
  logic [PW-1:0]   last_idx;

  // Index of the final buffered row: SIZE B rows followed by n A rows.
  assign last_idx = SIZE_P + PW'(n_q) - PW'(1);

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    res_cnt_d  = res_cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    err_d      = err_q;
    ld_we      = 1'b0;
    o_cfg_rdy  = 1'b0;
    o_ld_rdy   = 1'b0;
    o_sa_vld   = 1'b0;
    o_sa_is_b  = 1'b0;
    o_sa_ab    = '0;
    o_c_ready  = 1'b1;
    o_res_vld  = 1'b0;
    o_res_c    = '0;
    o_res_last = 1'b0;
    o_done     = 1'b0;
    o_busy     = (state_q != IDLE);
    o_err      = err_q;

    // Results pass straight through only while a result is still owed;
    // anything else is swallowed and flagged.
    res_act = ((state_q == SEND) || (state_q == DRAIN)) && (res_cnt_q < n_q);
    if (res_act) begin
      o_res_vld  = i_c_vld;
      o_res_c    = i_c;
      o_c_ready  = i_res_rdy;
      o_res_last = (res_cnt_q == n_q - 1'b1);
    end else if (i_c_vld) begin
      err_d = 1'b1;
    end
    c_hs = res_act & i_c_vld & i_res_rdy;
    if (c_hs) res_cnt_d = res_cnt_q + 1'b1;
    res_fin = (res_cnt_q == n_q) || (c_hs && (res_cnt_q == n_q - 1'b1));

    case (state_q)
      IDLE: begin
        o_cfg_rdy = 1'b1;
        if (i_cfg_vld) begin
          n_d       = (i_cfg_a_rows > AMAX_P) ? AMAX_P : i_cfg_a_rows;
          if (i_cfg_a_rows > AMAX_P) err_d = 1'b1;
          wr_ptr_d  = '0;
          rd_ptr_d  = '0;
          res_cnt_d = '0;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        o_ld_rdy = 1'b1;
        if (i_ld_vld) begin
          ld_we    = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (wr_ptr_q == last_idx) state_d = SEND;
        end
      end
      SEND: begin
        o_sa_vld  = 1'b1;
        o_sa_is_b = (rd_ptr_q < SIZE_P);
        o_sa_ab   = mem[rd_ptr_q];
        if (i_sa_ready) begin
          rd_ptr_d = rd_ptr_q + 1'b1;
          if (rd_ptr_q == last_idx) state_d = res_fin ? DONE : DRAIN;
        end
      end
      DRAIN: if (res_fin) state_d = DONE;
      DONE: begin
        o_done  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are held quiet for the whole reset cycle, not just after it.
    if (rst) begin
      ld_we      = 1'b0;
      o_cfg_rdy  = 1'b0;
      o_ld_rdy   = 1'b0;
      o_sa_vld   = 1'b0;
      o_sa_is_b  = 1'b0;
      o_sa_ab    = '0;
      o_c_ready  = 1'b0;
      o_res_vld  = 1'b0;
      o_res_c    = '0;
      o_res_last = 1'b0;
      o_done     = 1'b0;
      o_busy     = 1'b0;
      o_err      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      n_q       <= '0;
      res_cnt_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      res_cnt_q <= res_cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      err_q     <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ld_we) mem[wr_ptr_q] <= i_ld_row;
  end
endmodule

// File: tb/tb_sa_job_feeder.sv
// Bench for sa_job_feeder: idle/reset vector table, directed jobs and random jobs
// checked against a queue-based model of the job/row/result stream.
module tb_sa_job_feeder;
  localparam int WIDTH = 16, SIZE = 4, AMAX = 16;
  localparam int CNTW = $clog2(AMAX+1);
  localparam int RW = SIZE*WIDTH;

  logic clk = 1'b0, rst;
  logic i_cfg_vld, o_cfg_rdy, i_ld_vld, o_ld_rdy;
  logic [CNTW-1:0] i_cfg_a_rows;
  logic [RW-1:0] i_ld_row, o_sa_ab, i_c, o_res_c;
  logic o_sa_vld, o_sa_is_b, i_sa_ready, i_c_vld, o_c_ready;
  logic o_res_vld, o_res_last, i_res_rdy, o_done, o_busy, o_err;

  int n_chk = 0, n_pass = 0;
  bit err_exp = 1'b0;

  sa_job_feeder #(.WIDTH(WIDTH), .SIZE(SIZE), .A_ROWS_MAX(AMAX)) dut (
    .clk(clk), .rst(rst),
    .i_cfg_vld(i_cfg_vld), .i_cfg_a_rows(i_cfg_a_rows), .o_cfg_rdy(o_cfg_rdy),
    .i_ld_vld(i_ld_vld), .i_ld_row(i_ld_row), .o_ld_rdy(o_ld_rdy),
    .o_sa_vld(o_sa_vld), .o_sa_is_b(o_sa_is_b), .o_sa_ab(o_sa_ab), .i_sa_ready(i_sa_ready),
    .i_c_vld(i_c_vld), .i_c(i_c), .o_c_ready(o_c_ready),
    .o_res_vld(o_res_vld), .o_res_c(o_res_c), .o_res_last(o_res_last), .i_res_rdy(i_res_rdy),
    .o_done(o_done), .o_busy(o_busy), .o_err(o_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  typedef struct {
    bit rst, c_vld, res_rdy;
    bit cfg_rdy, c_ready, res_vld, busy, err;
  } vec_t;

  task automatic idle_inputs();
    i_cfg_vld = 0; i_cfg_a_rows = '0; i_ld_vld = 0; i_ld_row = '0;
    i_sa_ready = 0; i_c_vld = 0; i_c = '0; i_res_rdy = 0;
  endtask

  // One whole job: model is the list of rows in load order plus the expected results.
  task automatic run_job(input int ncfg, input int sa_pat, input int rp);
    int n, tot, loaded, sent, got, cyc;
    bit can_c;
    logic [RW-1:0] rows[$], res[$];
    n = (ncfg > AMAX) ? AMAX : ncfg;
    tot = SIZE + n;
    for (int i = 0; i < tot; i++) rows.push_back({$urandom, $urandom});
    for (int i = 0; i < n; i++) res.push_back({$urandom, $urandom});

    #1 chk("cfg_rdy_idle", o_cfg_rdy, 1);
    i_cfg_vld = 1; i_cfg_a_rows = CNTW'(ncfg);
    @(posedge clk); @(negedge clk);
    i_cfg_vld = 0;
    if (ncfg > AMAX) err_exp = 1'b1;

    loaded = 0; cyc = 0;
    while (loaded < tot && cyc < 2000) begin
      i_ld_vld = (rp == 0) ? 1'b1 : ($urandom % 2 == 1);
      i_ld_row = rows[loaded];
      #1;
      chk("ld_rdy", o_ld_rdy, 1);
      chk("ld_sa_vld", o_sa_vld, 0);
      chk("ld_cfg_rdy", o_cfg_rdy, 0);
      chk("ld_busy", o_busy, 1);
      chk("ld_err", o_err, err_exp);
      @(posedge clk);
      if (i_ld_vld) loaded++;
      @(negedge clk); cyc++;
    end
    i_ld_vld = 0;
    if (cyc >= 2000) chk("ld_timeout", 0, 1);
    chk("ld_count", loaded, tot);

    sent = 0; got = 0; cyc = 0;
    while ((sent < tot || got < n) && cyc < 4000) begin
      i_sa_ready = (sa_pat == 0) ? 1'b1 :
                   (sa_pat == 1) ? (cyc % 4 == 0 || cyc % 4 == 3) : ($urandom % 2 == 1);
      can_c = (got < n) && (sent >= SIZE) && (got <= sent - SIZE);
      i_c_vld = can_c && (rp == 0 || $urandom % 3 != 0);
      i_c = can_c ? res[got] : '0;
      i_res_rdy = (rp == 0) ? 1'b1 : ($urandom % 2 == 1);
      #1;
      chk("sa_vld", o_sa_vld, sent < tot);
      if (sent < tot) begin
        chk("sa_ab", o_sa_ab, rows[sent]);
        chk("sa_is_b", o_sa_is_b, sent < SIZE);
      end
      chk("res_vld", o_res_vld, i_c_vld);
      chk("c_ready", o_c_ready, (got < n) ? i_res_rdy : 1'b1);
      if (i_c_vld) begin
        chk("res_c", o_res_c, res[got]);
        chk("res_last", o_res_last, got == n - 1);
      end
      chk("done_early", o_done, 0);
      chk("send_err", o_err, err_exp);
      @(posedge clk);
      if (sent < tot && i_sa_ready) sent++;
      if (i_c_vld && i_res_rdy) got++;
      @(negedge clk); cyc++;
    end
    i_sa_ready = 0; i_c_vld = 0; i_c = '0;
    if (cyc >= 4000) chk("send_timeout", 0, 1);
    #1;
    chk("done_pulse", o_done, 1);
    chk("done_busy", o_busy, 1);
    @(posedge clk); @(negedge clk);
    #1;
    chk("done_once", o_done, 0);
    chk("post_cfg_rdy", o_cfg_rdy, 1);
    chk("post_busy", o_busy, 0);
    chk("post_err", o_err, err_exp);
  endtask

  initial begin
    vec_t tbl[7];
    idle_inputs();
    rst = 1;
    tbl[0] = '{1,0,1, 0,0,0,0,0};
    tbl[1] = '{0,0,0, 1,1,0,0,0};
    tbl[2] = '{0,0,1, 1,1,0,0,0};
    tbl[3] = '{0,1,0, 1,1,0,0,0};   // stray C row in IDLE
    tbl[4] = '{0,0,0, 1,1,0,0,1};   // error now sticky
    tbl[5] = '{1,1,1, 0,0,0,0,0};
    tbl[6] = '{0,0,0, 1,1,0,0,0};   // reset cleared the error
    @(posedge clk); @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      rst = tbl[i].rst; i_c_vld = tbl[i].c_vld; i_res_rdy = tbl[i].res_rdy;
      i_c = {$urandom, $urandom};
      #1;
      chk($sformatf("v%0d_cfg_rdy", i), o_cfg_rdy, tbl[i].cfg_rdy);
      chk($sformatf("v%0d_c_ready", i), o_c_ready, tbl[i].c_ready);
      chk($sformatf("v%0d_res_vld", i), o_res_vld, tbl[i].res_vld);
      chk($sformatf("v%0d_busy", i), o_busy, tbl[i].busy);
      chk($sformatf("v%0d_err", i), o_err, tbl[i].err);
      chk($sformatf("v%0d_ld_rdy", i), o_ld_rdy, 0);
      chk($sformatf("v%0d_sa_vld", i), o_sa_vld, 0);
      chk($sformatf("v%0d_done", i), o_done, 0);
      @(posedge clk); @(negedge clk);
    end
    idle_inputs();

    run_job(4, 0, 0);
    run_job(4, 1, 0);
    run_job(0, 0, 0);
    run_job(20, 0, 0);

    // Reset in the middle of SEND after three rows have gone out.
    i_cfg_vld = 1; i_cfg_a_rows = CNTW'(4);
    @(posedge clk); @(negedge clk);
    i_cfg_vld = 0;
    for (int i = 0; i < SIZE + 4; i++) begin
      i_ld_vld = 1; i_ld_row = {$urandom, $urandom};
      @(posedge clk); @(negedge clk);
    end
    i_ld_vld = 0;
    i_sa_ready = 1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("mid_sa_vld", o_sa_vld, 1);
      @(posedge clk); @(negedge clk);
    end
    i_sa_ready = 0; rst = 1;
    #1;
    chk("rst_sa_vld", o_sa_vld, 0);
    chk("rst_sa_ab", o_sa_ab, '0);
    chk("rst_c_ready", o_c_ready, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_err", o_err, 0);
    @(posedge clk); @(negedge clk);
    rst = 0; err_exp = 1'b0;
    #1;
    chk("after_rst_sa_vld", o_sa_vld, 0);
    chk("after_rst_err", o_err, 0);
    chk("after_rst_cfg_rdy", o_cfg_rdy, 1);
    @(negedge clk);
    run_job(4, 0, 0);

    for (int j = 0; j < 10; j++) run_job($urandom_range(0, 19), 2, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", n_pass, n_chk);
    $fatal(1);
  end
endmodule
